uart_word_bridge: RTL
=====================

// Module: uart_word_bridge
// PURPOSE
//   Responder side of the core's ISendRequest/IRecvRequest word I/O. Packs UART receive bytes into
//   32-bit words in an RX FIFO read by the core via recv_en/recv_rd/recv_size. Serialises words
//   written by the core via send_en/send_content into four UART transmit bytes.
//   Sits between the core and the UART byte-level rx/tx modules.
// PARAMETERS
//   RX_DEPTH  16  RX FIFO depth in words; power of two, >= 2
// PORTS
//   clock         in   1   system clock; all state updates on posedge
//   reset         in   1   synchronous, active-high reset
//   send_en       in   1   core send strobe; one word per cycle high
//   send_content  in   32  word to transmit; sampled when send_en=1
//   send_busy     out  1   transmitter cannot accept a word
//   recv_en       in   1   core pop request
//   recv_rd       out  32  popped word; valid the cycle after an accepted recv_en
//   recv_size     out  $clog2(RX_DEPTH)+1  words currently held in RX FIFO
//   rx_byte       in   8   byte from UART receiver
//   rx_valid      in   1   one-cycle pulse: rx_byte valid
//   tx_byte       out  8   byte to UART transmitter
//   tx_valid      out  1   tx_byte valid; held until tx_ready
//   tx_ready      in   1   transmitter accepts tx_byte when tx_valid & tx_ready
//   rx_overflow   out  1   sticky; a completed word was dropped because FIFO full
// BEHAVIOUR
//   Reset: send_busy=0 (when send_en=0), recv_rd=0, recv_size=0, tx_valid=0, tx_byte=0,
//     rx_overflow=0, byte assemblers cleared, TX FSM -> IDLE. Reset mid-word discards the partial word.
//   Byte order: little-endian both ways; first byte on the wire = bits [7:0].
//   RX assembly: 2-bit byte index; each rx_valid writes rx_byte into lane idx, idx+1 (wraps 3->0).
//     On the 4th byte the word is pushed the same edge, counted in recv_size the next cycle.
//     FIFO full at push: word dropped, rx_overflow<=1, idx still wraps to 0.
//   RX read: recv_en accepted iff recv_size!=0 (recv_en with size 0 ignored, recv_rd holds).
//     Accepted pop: recv_rd <= head word, rd pointer+1 (wraps mod RX_DEPTH), size-1.
//     recv_rd is registered, holds last popped word until next accepted pop.
//     Simultaneous push and pop: size unchanged; pop with size 1 and push same cycle returns old word.
//   TX FSM: IDLE -> SEND(k=0..3).
//     IDLE & send_en: latch send_content into shift reg, k=0, tx_valid<=1, tx_byte<=[7:0].
//     SEND: on tx_valid&tx_ready present next byte (k+1); after byte 3 accepted -> IDLE, tx_valid<=0.
//     tx_byte stable while tx_valid & !tx_ready.
//   send_busy = (state!=IDLE) | send_en  (combinational term on send_en so a core that re-tests busy
//     in the cycle its strobe is high sees busy=1; no back-to-back strobe loss).
//   send_en while busy (state!=IDLE): ignored, word lost; core must respect send_busy.
//   Throughput: next word accepted the cycle after the 4th byte handshake.
// TESTING
//   1 RX: reset, feed bytes 78 56 34 12 -> recv_size 0->1 next cycle; recv_en 1 cycle -> recv_rd=0x12345678
//     the cycle after, size=0.
//   2 TX: send_en with 0xDEADBEEF, tx_ready=1 -> tx_byte EF,BE,AD,DE on 4 consecutive cycles,
//     send_busy high from send_en cycle through last byte, low the cycle after.
//   3 Backpressure: tx_ready toggling 1/0 -> byte sequence unchanged, tx_byte stable while stalled.
//   4 Full: push RX_DEPTH+1 words, no reads -> recv_size=16, rx_overflow=1, reads return words 0..15 in order.
//   5 Edges: recv_en at size 0 -> no change; push+pop same cycle at size 1 -> size stays 1, FIFO order kept.
//   6 Reset mid-op: 2 of 4 RX bytes and TX at byte 1 -> reset -> size 0, tx_valid 0; next 4 bytes form a clean word.

Source files
------------

// File: rtl/uart_word_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uart_word_bridge
//  Purpose  : Packs UART receive bytes into 32-bit words and queues them for
//             the core. Serialises core words into four UART transmit bytes.
//             Both directions are little-endian.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_word_bridge #(
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          send_en,
    input  logic [31:0]                   send_content,
    output logic                          send_busy,
    input  logic                          recv_en,
    output logic [31:0]                   recv_rd,
    output logic [$clog2(RX_DEPTH):0]     recv_size,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_valid,
    output logic [7:0]                    tx_byte,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          rx_overflow
);

    localparam int unsigned c_ADDR_W = $clog2(RX_DEPTH);
    localparam int unsigned c_SIZE_W = c_ADDR_W + 1;
    localparam logic [c_SIZE_W-1:0] c_DEPTH = c_SIZE_W'(RX_DEPTH);

    // ---------------- RX byte assembly and word FIFO ----------------
    logic [1:0]           idx_q;
    logic [23:0]          lanes_q;
    logic [31:0]          mem_q [RX_DEPTH];
    logic [c_ADDR_W-1:0]  wr_ptr_q;
    logic [c_ADDR_W-1:0]  rd_ptr_q;
    logic [c_SIZE_W-1:0]  size_q;
    logic [31:0]          rd_word_q;
    logic                 ovf_q;

    logic [31:0] w_word;
    logic        w_word_done;
    logic        w_full;
    logic        w_push;
    logic        w_pop;

    assign w_word      = {rx_byte, lanes_q};
    assign w_word_done = rx_valid && (idx_q == 2'd3);
    assign w_full      = (size_q == c_DEPTH);
    assign w_push      = w_word_done && !w_full;
    assign w_pop       = recv_en && (size_q != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q     <= 2'd0;
            lanes_q   <= 24'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            size_q    <= '0;
            rd_word_q <= 32'd0;
            ovf_q     <= 1'b0;
        end else begin
            if (rx_valid) begin
                idx_q <= idx_q + 2'd1;
                case (idx_q)
                    2'd0:    lanes_q[7:0]   <= rx_byte;
                    2'd1:    lanes_q[15:8]  <= rx_byte;
                    2'd2:    lanes_q[23:16] <= rx_byte;
                    default: lanes_q        <= lanes_q;
                endcase
            end
            if (w_word_done && w_full) begin
                ovf_q <= 1'b1;
            end
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_word_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   size_q <= size_q + 1'b1;
                2'b01:   size_q <= size_q - 1'b1;
                default: size_q <= size_q;
            endcase
        end
    end

    // Storage needs no reset: only slots counted by size_q are ever read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_word;
        end
    end

    assign recv_rd     = rd_word_q;
    assign recv_size   = size_q;
    assign rx_overflow = ovf_q;

    // ---------------- TX word serialiser ----------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    tx_state_t   state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0]  txb_q, txb_d;
    logic        txv_q, txv_d;
    logic [1:0]  w_k_next;

    assign w_k_next = k_q + 2'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= 2'd0;
            sh_q    <= 32'd0;
            txb_q   <= 8'd0;
            txv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sh_q    <= sh_d;
            txb_q   <= txb_d;
            txv_q   <= txv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sh_d    = sh_q;
        txb_d   = txb_q;
        txv_d   = txv_q;
        case (state_q)
            ST_IDLE: begin
                if (send_en) begin
                    state_d = ST_SEND;
                    sh_d    = send_content;
                    k_d     = 2'd0;
                    txb_d   = send_content[7:0];
                    txv_d   = 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (k_q == 2'd3) begin
                        state_d = ST_IDLE;
                        txv_d   = 1'b0;
                    end else begin
                        k_d   = w_k_next;
                        txb_d = sh_q[{w_k_next, 3'b000} +: 8];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // send_en term lets a core re-testing busy in its strobe cycle see it set.
    assign send_busy = (state_q != ST_IDLE) || send_en;
    assign tx_byte   = txb_q;
    assign tx_valid  = txv_q;

endmodule
`default_nettype wire
